// File: rtl/sound_square_regs_pkg.sv
// Shared register offsets, read masks and the stored field layout for the
// square-channel register front end.
package sound_square_regs_pkg;

  localparam logic [2:0] NR_SWEEP   = 3'd0;
  localparam logic [2:0] NR_DUTY    = 3'd1;
  localparam logic [2:0] NR_ENV     = 3'd2;
  localparam logic [2:0] NR_FREQ_LO = 3'd3;
  localparam logic [2:0] NR_FREQ_HI = 3'd4;

  // Bits that are write-only or unimplemented read back as 1.
  localparam logic [7:0] RD_MASK_SWEEP   = 8'h80;
  localparam logic [7:0] RD_MASK_DUTY    = 8'h3F;
  localparam logic [7:0] RD_MASK_ENV     = 8'h00;
  localparam logic [7:0] RD_MASK_FREQ_LO = 8'hFF;
  localparam logic [7:0] RD_MASK_FREQ_HI = 8'hBF;

  typedef struct packed {
    logic [2:0]  sweep_time;
    logic        sweep_decreasing;
    logic [2:0]  num_sweep_shifts;
    logic [1:0]  wave_duty;
    logic [5:0]  length;
    logic [3:0]  initial_volume;
    logic        envelope_increasing;
    logic [2:0]  num_envelope_sweeps;
    logic [10:0] frequency;
    logic        single;
  } sq_fields_t;

  function automatic logic [7:0] rd_merge(input logic [7:0] stored, input logic [7:0] mask);
    return stored | mask;
  endfunction

endpackage

// File: rtl/sound_edge_det.sv
// Registers a level and reports its rising and falling edges as one-cycle
// combinational pulses relative to the previous sampled value.
module sound_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_level_q;

  always_ff @(posedge clk) begin
    if (!rst) r_level_q <= 1'b0;
    else      r_level_q <= i_level;
  end

  assign o_rise = i_level & ~r_level_q;
  assign o_fall = ~i_level & r_level_q;

endmodule

// File: rtl/sound_square_regs.sv
// CPU register front end for one square channel: NRx0..NRx4 decode, trigger
// pulse, masked readback and the NR52 channel-on status bit.
module sound_square_regs
  import sound_square_regs_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF10,
  parameter bit          HAS_SWEEP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        wr,
  input  logic        rd,
  output logic [7:0]  dout,
  output logic        sel,
  input  logic        sound_on,
  input  logic        chan_enable,
  output logic [2:0]  sweep_time,
  output logic        sweep_decreasing,
  output logic [2:0]  num_sweep_shifts,
  output logic [1:0]  wave_duty,
  output logic [5:0]  length,
  output logic [3:0]  initial_volume,
  output logic        envelope_increasing,
  output logic [2:0]  num_envelope_sweeps,
  output logic [10:0] frequency,
  output logic        single,
  output logic        start,
  output logic        dac_en,
  output logic        ch_status
);

  logic [15:0] w_addr_diff;
  logic        w_in_range;
  logic [2:0]  w_off;
  logic        w_wr_rise;
  logic        w_en_fall;
  logic        w_unused_wr_fall;
  logic        w_unused_en_rise;
  logic        w_accept;
  logic        w_trigger;
  logic        w_dac_en;
  logic [7:0]  w_rd_data;

  sq_fields_t  r_f;
  logic        r_start;
  logic        r_ch_status;
  logic [7:0]  r_dout;
  logic        r_sel;

  // Addresses below BASE wrap to large values, so one compare covers both ends.
  assign w_addr_diff = addr - BASE_ADDR;
  assign w_in_range  = (w_addr_diff <= 16'd4);
  assign w_off       = w_addr_diff[2:0];

  sound_edge_det u_wr_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (wr),
    .o_rise  (w_wr_rise),
    .o_fall  (w_unused_wr_fall)
  );

  sound_edge_det u_en_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (chan_enable),
    .o_rise  (w_unused_en_rise),
    .o_fall  (w_en_fall)
  );

  assign w_accept  = w_wr_rise & w_in_range & sound_on;
  assign w_trigger = w_accept & (w_off == NR_FREQ_HI) & din[7];
  assign w_dac_en  = |{r_f.initial_volume, r_f.envelope_increasing};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_f <= '0;
    end else if (!sound_on) begin
      r_f <= '0;
    end else if (w_accept) begin
      case (w_off)
        NR_SWEEP: begin
          if (HAS_SWEEP) begin
            r_f.sweep_time       <= din[6:4];
            r_f.sweep_decreasing <= din[3];
            r_f.num_sweep_shifts <= din[2:0];
          end
        end
        NR_DUTY: begin
          r_f.wave_duty <= din[7:6];
          r_f.length    <= din[5:0];
        end
        NR_ENV: begin
          r_f.initial_volume      <= din[7:4];
          r_f.envelope_increasing <= din[3];
          r_f.num_envelope_sweeps <= din[2:0];
        end
        NR_FREQ_LO: r_f.frequency[7:0] <= din;
        NR_FREQ_HI: begin
          r_f.frequency[10:8] <= din[2:0];
          r_f.single          <= din[6];
        end
        default: ;
      endcase
    end
  end

  // Status is set on the same edge that launches start so both rise together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_start     <= 1'b0;
      r_ch_status <= 1'b0;
    end else begin
      r_start <= w_trigger;
      if (!sound_on || !w_dac_en) r_ch_status <= 1'b0;
      else if (w_trigger)         r_ch_status <= 1'b1;
      else if (w_en_fall)         r_ch_status <= 1'b0;
    end
  end

  always_comb begin
    w_rd_data = 8'hFF;
    if (w_in_range) begin
      case (w_off)
        NR_SWEEP:   w_rd_data = HAS_SWEEP ?
                      rd_merge({1'b0, r_f.sweep_time, r_f.sweep_decreasing, r_f.num_sweep_shifts},
                               RD_MASK_SWEEP) : 8'hFF;
        NR_DUTY:    w_rd_data = rd_merge({r_f.wave_duty, r_f.length}, RD_MASK_DUTY);
        NR_ENV:     w_rd_data = rd_merge({r_f.initial_volume, r_f.envelope_increasing,
                                          r_f.num_envelope_sweeps}, RD_MASK_ENV);
        NR_FREQ_LO: w_rd_data = rd_merge(r_f.frequency[7:0], RD_MASK_FREQ_LO);
        NR_FREQ_HI: w_rd_data = rd_merge({1'b0, r_f.single, 3'b000, r_f.frequency[10:8]},
                                         RD_MASK_FREQ_HI);
        default:    w_rd_data = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dout <= 8'hFF;
      r_sel  <= 1'b0;
    end else begin
      if (rd) r_dout <= w_rd_data;
      r_sel <= w_in_range;
    end
  end

  assign dout                = r_dout;
  assign sel                 = r_sel;
  assign sweep_time          = r_f.sweep_time;
  assign sweep_decreasing    = r_f.sweep_decreasing;
  assign num_sweep_shifts    = r_f.num_sweep_shifts;
  assign wave_duty           = r_f.wave_duty;
  assign length              = r_f.length;
  assign initial_volume      = r_f.initial_volume;
  assign envelope_increasing = r_f.envelope_increasing;
  assign num_envelope_sweeps = r_f.num_envelope_sweeps;
  assign frequency           = r_f.frequency;
  assign single              = r_f.single;
  assign start               = r_start;
  assign dac_en              = w_dac_en;
  assign ch_status           = r_ch_status;

endmodule

// File: tb/tb_sound_square_regs.sv
// Directed bench for sound_square_regs: channel-1 instance at FF10 plus a
// sweep-less channel-2 instance at FF15 sharing the same bus.
module tb_sound_square_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        wr;
  logic        rd;
  logic        sound_on;
  logic        chan_enable;

  logic [7:0]  dout, c2_dout;
  logic        sel, c2_sel;
  logic [2:0]  sweep_time, c2_sweep_time;
  logic        sweep_decreasing, c2_sweep_decreasing;
  logic [2:0]  num_sweep_shifts, c2_num_sweep_shifts;
  logic [1:0]  wave_duty, c2_wave_duty;
  logic [5:0]  length, c2_length;
  logic [3:0]  initial_volume, c2_initial_volume;
  logic        envelope_increasing, c2_envelope_increasing;
  logic [2:0]  num_envelope_sweeps, c2_num_envelope_sweeps;
  logic [10:0] frequency, c2_frequency;
  logic        single, c2_single;
  logic        start, c2_start;
  logic        dac_en, c2_dac_en;
  logic        ch_status, c2_ch_status;

  int          checks = 0;
  int          failures = 0;
  int          start_cnt = 0;
  int          base_cnt;
  logic        seen_start;
  logic        seen_status;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  sound_square_regs #(.BASE_ADDR(16'hFF10), .HAS_SWEEP(1'b1)) u_dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .wr(wr), .rd(rd),
    .dout(dout), .sel(sel), .sound_on(sound_on), .chan_enable(chan_enable),
    .sweep_time(sweep_time), .sweep_decreasing(sweep_decreasing),
    .num_sweep_shifts(num_sweep_shifts), .wave_duty(wave_duty), .length(length),
    .initial_volume(initial_volume), .envelope_increasing(envelope_increasing),
    .num_envelope_sweeps(num_envelope_sweeps), .frequency(frequency), .single(single),
    .start(start), .dac_en(dac_en), .ch_status(ch_status)
  );

  sound_square_regs #(.BASE_ADDR(16'hFF15), .HAS_SWEEP(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .wr(wr), .rd(rd),
    .dout(c2_dout), .sel(c2_sel), .sound_on(sound_on), .chan_enable(chan_enable),
    .sweep_time(c2_sweep_time), .sweep_decreasing(c2_sweep_decreasing),
    .num_sweep_shifts(c2_num_sweep_shifts), .wave_duty(c2_wave_duty), .length(c2_length),
    .initial_volume(c2_initial_volume), .envelope_increasing(c2_envelope_increasing),
    .num_envelope_sweeps(c2_num_envelope_sweeps), .frequency(c2_frequency), .single(c2_single),
    .start(c2_start), .dac_en(c2_dac_en), .ch_status(c2_ch_status)
  );

  always @(negedge clk) if (start) start_cnt++;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds wr for hold cycles; records start/ch_status right after the accepting edge.
  task automatic wr_reg(input logic [15:0] a, input logic [7:0] d, input int hold);
    addr = a;
    din  = d;
    wr   = 1'b1;
    tick();
    seen_start  = start;
    seen_status = ch_status;
    repeat (hold - 1) tick();
    wr = 1'b0;
    tick();
  endtask

  task automatic rd_reg(input logic [15:0] a, input logic [7:0] exp, input string tag);
    addr = a;
    rd   = 1'b1;
    exp_q.push_back(exp);
    tick();
    rd = 1'b0;
    check(tag, {8'h00, dout}, {8'h00, exp_q.pop_front()});
  endtask

  initial begin
    rst = 1'b0; addr = 16'h0000; din = 8'h00; wr = 1'b0; rd = 1'b0;
    sound_on = 1'b1; chan_enable = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();

    check("rst_dout", dout, 8'hFF);
    check("rst_sel", sel, 1'b0);
    check("rst_start", start, 1'b0);
    check("rst_ch_status", ch_status, 1'b0);
    check("rst_frequency", frequency, 11'h000);
    check("rst_dac_en", dac_en, 1'b0);

    rd_reg(16'hFF10, 8'h80, "rd_nr0_rst");
    rd_reg(16'hFF11, 8'h3F, "rd_nr1_rst");
    rd_reg(16'hFF12, 8'h00, "rd_nr2_rst");
    rd_reg(16'hFF13, 8'hFF, "rd_nr3_rst");
    rd_reg(16'hFF14, 8'hBF, "rd_nr4_rst");
    check("sel_in_range", sel, 1'b1);
    check("c2_sel_below", c2_sel, 1'b0);
    rd_reg(16'hFF15, 8'hFF, "rd_ch1_above");
    check("sel_above", sel, 1'b0);
    check("c2_nr0_nosweep", c2_dout, 8'hFF);
    check("c2_sel_base", c2_sel, 1'b1);
    rd_reg(16'hFF16, 8'hFF, "rd_ch1_ff16");
    check("c2_nr1_rst", c2_dout, 8'h3F);

    // Basic trigger sequence
    base_cnt = start_cnt;
    wr_reg(16'hFF12, 8'hF3, 1);
    wr_reg(16'hFF13, 8'hD6, 1);
    wr_reg(16'hFF14, 8'h87, 1);
    check("trig_start_seen", seen_start, 1'b1);
    check("trig_status_same", seen_status, 1'b1);
    check("trig_start_count", start_cnt - base_cnt, 1);
    check("trig_start_low", start, 1'b0);
    check("trig_frequency", frequency, 11'h7D6);
    check("trig_volume", initial_volume, 4'hF);
    check("trig_env_sweeps", num_envelope_sweeps, 3'd3);
    check("trig_single", single, 1'b0);
    check("trig_dac_en", dac_en, 1'b1);
    check("c2_freq_untouched", c2_frequency, 11'h000);

    chan_enable = 1'b1;
    tick();

    // Held write is a single write
    base_cnt = start_cnt;
    wr_reg(16'hFF14, 8'hC0, 5);
    check("hold_start_count", start_cnt - base_cnt, 1);
    check("hold_single", single, 1'b1);
    check("hold_frequency", frequency, 11'h0D6);
    rd_reg(16'hFF14, 8'hFF, "rd_nr4_single");
    check("hold_status", ch_status, 1'b1);

    // Falling edge of chan_enable clears status; set beats same-cycle fall
    chan_enable = 1'b0;
    tick();
    check("fall_clears", ch_status, 1'b0);
    chan_enable = 1'b1;
    tick();
    addr = 16'hFF14; din = 8'h80; wr = 1'b1; chan_enable = 1'b0;
    tick();
    check("set_beats_fall", ch_status, 1'b1);
    check("set_beats_fall_start", start, 1'b1);
    wr = 1'b0;
    tick();

    // DAC off clears status and blocks set
    chan_enable = 1'b1;
    tick();
    wr_reg(16'hFF12, 8'h07, 1);
    check("dac_off", dac_en, 1'b0);
    check("dac_off_status", ch_status, 1'b0);
    base_cnt = start_cnt;
    wr_reg(16'hFF14, 8'h80, 1);
    check("dac_off_trig_start", seen_start, 1'b1);
    check("dac_off_trig_count", start_cnt - base_cnt, 1);
    check("dac_off_trig_status", seen_status, 1'b0);
    check("dac_off_status_after", ch_status, 1'b0);

    // Power off
    wr_reg(16'hFF12, 8'hF0, 1);
    wr_reg(16'hFF14, 8'h80, 1);
    check("pre_off_status", seen_status, 1'b1);
    sound_on = 1'b0;
    tick();
    check("off_status", ch_status, 1'b0);
    check("off_frequency", frequency, 11'h000);
    check("off_volume", initial_volume, 4'h0);
    rd_reg(16'hFF12, 8'h00, "rd_off_nr2");
    rd_reg(16'hFF11, 8'h3F, "rd_off_nr1");
    base_cnt = start_cnt;
    wr_reg(16'hFF14, 8'hC7, 1);
    check("off_no_start", seen_start, 1'b0);
    check("off_start_count", start_cnt - base_cnt, 0);
    check("off_single", single, 1'b0);
    check("off_frequency_wr", frequency, 11'h000);
    rd_reg(16'hFF10, 8'h80, "rd_off_nr0");

    // Reset arriving with a write in progress
    sound_on = 1'b1;
    base_cnt = start_cnt;
    addr = 16'hFF14; din = 8'hC0; wr = 1'b1; rst = 1'b0;
    tick();
    tick();
    wr = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_wr_count", start_cnt - base_cnt, 0);
    check("rst_mid_wr_dout", dout, 8'hFF);
    check("rst_mid_wr_single", single, 1'b0);

    // Read and write to the same register in one cycle
    addr = 16'hFF11; din = 8'h85; rd = 1'b1; wr = 1'b1;
    tick();
    rd = 1'b0; wr = 1'b0;
    check("rdwr_prewrite", dout, 8'h3F);
    check("rdwr_duty", wave_duty, 2'd2);
    check("rdwr_length", length, 6'd5);
    addr = 16'hFF13;
    tick();
    check("dout_hold", dout, 8'h3F);
    rd_reg(16'hFF11, 8'hBF, "rd_nr1_after");
    rd_reg(16'hFF20, 8'hFF, "rd_out_of_range");
    check("sel_out_of_range", sel, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
